// File: rtl/matmul_seq_ctrl.sv
// Job sequencer for the 4x4 systolic matmul array: latches A/B, clears the array,
// streams skewed operand lanes, and gathers the result columns into D.
module matmul_seq_ctrl #(
    parameter int unsigned DW = 32,
    parameter int unsigned N  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    input  logic              job_valid,
    output logic              job_ready,
    output logic [N*N*DW-1:0] d_flat,
    output logic              d_valid,
    input  logic              d_ready,
    output logic              busy,
    output logic              err,
    output logic              mm_rst,
    output logic              mm_input_start,
    output logic [N*DW-1:0]   mm_inA_flat,
    output logic [N*DW-1:0]   mm_inB_flat,
    output logic [3:0]        mm_counter,
    input  logic [N*DW-1:0]   mm_outD_flat,
    input  logic              mm_output_rdy
);

    localparam int unsigned MW = N * N * DW;
    localparam int unsigned LW = N * DW;
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cyc;
    logic [3:0]      w_cyc_nxt;
    logic [DW-1:0]   r_a [N][N];
    logic [DW-1:0]   r_b [N][N];
    logic [DW-1:0]   r_d [N][N];
    logic [LW-1:0]   w_ina_nxt;
    logic [LW-1:0]   w_inb_nxt;
    logic [3:0]      w_cnt_nxt;
    logic            w_accept;
    logic            w_release;
    logic            w_capture;
    logic [IW-1:0]   w_col;
    int              w_idx;

    assign job_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_CLEAR) || (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_accept  = job_valid & job_ready;
    assign w_release = d_valid & d_ready;
    assign w_capture = (r_state == S_DRAIN) && (r_cyc >= 4'd9);
    assign w_col     = IW'(r_cyc - 4'd9);

    // Next state and job cycle index (r_cyc holds n of the current Cn)
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CLEAR;
                    w_cyc_nxt   = 4'd0;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_FEED;
                w_cyc_nxt   = r_cyc + 4'd1;
            end
            S_FEED: begin
                w_cyc_nxt = r_cyc + 4'd1;
                if (r_cyc == 4'd7) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_cyc_nxt = r_cyc + 4'd1;
                if (r_cyc == 4'd12) begin
                    w_state_nxt = S_DONE;
                    w_cyc_nxt   = 4'd0;
                end
            end
            S_DONE: begin
                if (w_release) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lane and counter values for the upcoming cycle; out-of-range skew indices stay zero
    always_comb begin
        w_ina_nxt = '0;
        w_inb_nxt = '0;
        w_cnt_nxt = '0;
        w_idx     = 0;
        if (w_state_nxt == S_FEED) begin
            for (int k = 0; k < int'(N); k++) begin
                w_idx = int'(w_cyc_nxt) - 1 - k;
                if (w_idx >= 0 && w_idx < int'(N)) begin
                    w_inb_nxt[LW-1-DW*k -: DW] = r_a[IW'(k)][IW'(w_idx)];
                    w_ina_nxt[LW-1-DW*k -: DW] = r_b[IW'(w_idx)][IW'(k)];
                end
            end
        end
        if ((w_state_nxt == S_CLEAR || w_state_nxt == S_FEED || w_state_nxt == S_DRAIN)
            && w_cyc_nxt >= 4'd2) begin
            w_cnt_nxt = w_cyc_nxt - 4'd2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cyc          <= '0;
            d_valid        <= 1'b0;
            err            <= 1'b0;
            mm_rst         <= 1'b1;
            mm_input_start <= 1'b0;
            mm_inA_flat    <= '0;
            mm_inB_flat    <= '0;
            mm_counter     <= '0;
            for (int i = 0; i < int'(N); i++) begin
                for (int j = 0; j < int'(N); j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                    r_d[i][j] <= '0;
                end
            end
        end else begin
            r_state        <= w_state_nxt;
            r_cyc          <= w_cyc_nxt;
            mm_rst         <= 1'b0;
            mm_input_start <= (w_state_nxt == S_CLEAR);
            mm_inA_flat    <= w_ina_nxt;
            mm_inB_flat    <= w_inb_nxt;
            mm_counter     <= w_cnt_nxt;
            if (w_accept) begin
                err <= 1'b0;
                for (int i = 0; i < int'(N); i++) begin
                    for (int j = 0; j < int'(N); j++) begin
                        r_a[i][j] <= a_flat[MW-1-DW*(N*i+j) -: DW];
                        r_b[i][j] <= b_flat[MW-1-DW*(N*i+j) -: DW];
                    end
                end
            end
            // Column capture happens regardless of output_rdy; a missing rdy only flags err
            if (w_capture) begin
                if (!mm_output_rdy) err <= 1'b1;
                for (int r = 0; r < int'(N); r++) begin
                    r_d[r][w_col] <= mm_outD_flat[LW-1-DW*r -: DW];
                end
            end
            if (r_state == S_DRAIN && r_cyc == 4'd12) begin
                d_valid <= 1'b1;
            end else if (w_release) begin
                d_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        d_flat = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                d_flat[MW-1-DW*(N*i+j) -: DW] = r_d[i][j];
            end
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl with a behavioural systolic array that
// multiplies whatever the controller streams on its lanes.
module tb_matmul_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [511:0] a_flat = '0;
    logic [511:0] b_flat = '0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [511:0] d_flat;
    logic         d_valid;
    logic         d_ready = 1'b0;
    logic         busy;
    logic         err;
    logic         mm_rst;
    logic         mm_input_start;
    logic [127:0] mm_inA_flat;
    logic [127:0] mm_inB_flat;
    logic [3:0]   mm_counter;
    logic [127:0] mm_outD_flat;
    logic         mm_output_rdy;

    logic         nrdy_en = 1'b0;
    int           checks = 0;
    int           failures = 0;

    logic [31:0]  row_h [7][4];
    logic [31:0]  col_h [7][4];
    logic [31:0]  dm [4][4];
    int           step = 7;
    int           col;

    matmul_seq_ctrl #(.DW(32), .N(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .a_flat         (a_flat),
        .b_flat         (b_flat),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .d_flat         (d_flat),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .busy           (busy),
        .err            (err),
        .mm_rst         (mm_rst),
        .mm_input_start (mm_input_start),
        .mm_inA_flat    (mm_inA_flat),
        .mm_inB_flat    (mm_inB_flat),
        .mm_counter     (mm_counter),
        .mm_outD_flat   (mm_outD_flat),
        .mm_output_rdy  (mm_output_rdy)
    );

    always #5 clk = ~clk;

    // Array model: a row lane i sent at step s meets column lane j sent at step s'
    // in PE(i,j) when s+j == s'+i.
    always @(negedge clk) begin
        if (mm_input_start) begin
            step = 0;
        end else if (step < 7) begin
            for (int l = 0; l < 4; l++) begin
                row_h[step][l] = mm_inB_flat[127-32*l -: 32];
                col_h[step][l] = mm_inA_flat[127-32*l -: 32];
            end
            step++;
            if (step == 7) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        logic [31:0] acc;
                        acc = '0;
                        for (int t = 0; t < 13; t++) begin
                            if (t - j >= 0 && t - j < 7 && t - i >= 0 && t - i < 7)
                                acc = acc + row_h[t-j][i] * col_h[t-i][j];
                        end
                        dm[i][j] = acc;
                    end
                end
            end
        end
    end

    always_comb begin
        mm_outD_flat  = '0;
        mm_output_rdy = 1'b0;
        col           = 0;
        if (mm_counter >= 4'd7 && mm_counter <= 4'd10) begin
            col = int'(mm_counter) - 7;
            for (int r = 0; r < 4; r++) mm_outD_flat[127-32*r -: 32] = dm[r][col];
            mm_output_rdy = !(nrdy_en && mm_counter == 4'd8);
        end
    end

    function automatic logic [511:0] fill(input int mode);
        logic [511:0] p;
        logic [31:0]  e;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (mode)
                    0:       e = (i == j) ? 32'd1 : 32'd0;
                    1:       e = 32'(4*i + j + 1);
                    2:       e = 32'd2;
                    3:       e = 32'd3;
                    4:       e = 32'(i + 1);
                    5:       e = 32'(j + 1);
                    6:       e = 32'h0001_0000;
                    7:       e = 32'd24;
                    8:       e = 32'(4*(i+1)*(j+1));
                    default: e = '0;
                endcase
                p[511-32*(4*i+j) -: 32] = e;
            end
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [511:0] a, input logic [511:0] b);
        int k;
        k = 0;
        a_flat    = a;
        b_flat    = b;
        job_valid = 1'b1;
        while (!job_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", 512'(job_ready), 512'(1'b1));
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_dv(input int start, output int lat);
        lat = start;
        while (!d_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        chk("popped", 512'(d_valid), 512'(1'b0));
    endtask

    initial begin
        int   lat;
        logic saw;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 512'({d_valid, busy, err, mm_input_start, job_ready, mm_rst}), 512'(6'b000011));
        chk("rst_lanes", 512'({mm_inA_flat, mm_inB_flat, mm_counter}), '0);
        chk("rst_dflat", d_flat, '0);
        rst = 1'b1;
        #1 chk("mm_rst_hold", 512'(mm_rst), 512'(1'b1));
        @(negedge clk);
        chk("mm_rst_drop", 512'(mm_rst), 512'(1'b0));

        // Job 1: identity x B, with lane/counter spot checks
        start_job(fill(0), fill(1));
        chk("c0_ctl", 512'({mm_input_start, busy, job_ready, mm_counter}), 512'({3'b110, 4'd0}));
        @(negedge clk);
        chk("c1_inB", 512'(mm_inB_flat), 512'({32'd1, 96'd0}));
        chk("c1_inA", 512'(mm_inA_flat), 512'({32'd1, 96'd0}));
        repeat (3) @(negedge clk);
        chk("c4_inA", 512'(mm_inA_flat), 512'({32'd13, 32'd10, 32'd7, 32'd4}));
        chk("c4_inB", 512'(mm_inB_flat), '0);
        chk("c4_cnt", 512'(mm_counter), 512'(4'd2));
        repeat (5) @(negedge clk);
        chk("c9_cnt", 512'(mm_counter), 512'(4'd7));
        chk("c9_lanes", 512'({mm_inA_flat, mm_inB_flat}), '0);
        wait_dv(9, lat);
        chk("latency_j1", 512'(lat), 512'(13));
        chk("d_identity", d_flat, fill(1));
        chk("done_ctl", 512'({err, busy, job_ready}), 512'(3'b000));
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        chk("idle_after", 512'({d_valid, job_ready}), 512'(2'b01));
        chk("dflat_kept", d_flat, fill(1));

        // Job 2: d_ready held high throughout has no early effect
        d_ready = 1'b1;
        start_job(fill(2), fill(3));
        wait_dv(0, lat);
        chk("latency_j2", 512'(lat), 512'(13));
        chk("d_all24", d_flat, fill(7));
        @(negedge clk);
        d_ready = 1'b0;
        chk("early_ready_release", 512'(d_valid), 512'(1'b0));

        // Job 3: rank-one product
        start_job(fill(4), fill(5));
        wait_dv(0, lat);
        chk("d_outer", d_flat, fill(8));
        chk("d33", 512'(d_flat[31:0]), 512'(32'd64));
        chk("d02", 512'(d_flat[447:416]), 512'(32'd12));
        pop();

        // Job 4: products wrap to zero
        start_job(fill(6), fill(6));
        wait_dv(0, lat);
        chk("d_wrap", d_flat, '0);
        pop();

        // Backpressure with a second job pending
        start_job(fill(2), fill(3));
        wait_dv(0, lat);
        a_flat    = fill(4);
        b_flat    = fill(5);
        job_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_dflat", d_flat, fill(7));
            chk("bp_ctl", 512'({d_valid, job_ready, busy}), 512'(3'b100));
        end
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        chk("bp_exit", 512'({d_valid, job_ready, busy, mm_input_start}), 512'(4'b0100));
        @(negedge clk);
        chk("bp_accept", 512'({busy, mm_input_start}), 512'(2'b11));
        job_valid = 1'b0;
        wait_dv(0, lat);
        chk("latency_bp", 512'(lat), 512'(13));
        chk("bp_second", d_flat, fill(8));
        pop();

        // Abort during FEED
        start_job(fill(4), fill(5));
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ctl", 512'({d_valid, busy, err, mm_input_start, job_ready, mm_rst}), 512'(6'b000011));
        chk("abort_lanes", 512'({mm_inA_flat, mm_inB_flat, mm_counter}), '0);
        chk("abort_dflat", d_flat, '0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("abort_mm_rst_hold", 512'(mm_rst), 512'(1'b1));
        @(negedge clk);
        chk("abort_mm_rst_drop", 512'({mm_rst, job_ready}), 512'(2'b01));
        saw = 1'b0;
        repeat (16) begin
            @(negedge clk);
            saw = saw | d_valid;
        end
        chk("abort_no_dvalid", 512'(saw), 512'(1'b0));

        // Missing output_rdy at the C10 capture
        nrdy_en = 1'b1;
        start_job(fill(4), fill(5));
        wait_dv(0, lat);
        chk("err_set", 512'(err), 512'(1'b1));
        chk("err_dflat", d_flat, fill(8));
        repeat (2) @(negedge clk);
        chk("err_held", 512'({err, d_valid}), 512'(2'b11));
        pop();
        chk("err_sticky_idle", 512'(err), 512'(1'b1));
        nrdy_en = 1'b0;
        start_job(fill(2), fill(3));
        chk("err_cleared", 512'(err), 512'(1'b0));
        wait_dv(0, lat);
        chk("d_after_err", d_flat, fill(7));
        pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
